energy_min_tracker: RTL



---
 rtl/energy_min_tracker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/energy_min_tracker.sv
// Energy minimum tracker: consumes a configured number of signed energy samples
// and reports the minimum and its first index. Optional running sum: ENERGY_MIN_TRACKER_SUM_EN.
module energy_min_tracker #(
  parameter int ENERGY_BITS = 32,
  parameter int INDEX_BITS  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic                          flush_i,
  input  logic                          cfg_valid_i,
  output logic                          cfg_ready_o,
  input  logic [INDEX_BITS-1:0]         cfg_num_samples_i,
  input  logic                          energy_valid_i,
  output logic                          energy_ready_o,
  input  logic signed [ENERGY_BITS-1:0] energy_i,
  output logic                          result_valid_o,
  input  logic                          result_ready_i,
  output logic signed [ENERGY_BITS-1:0] min_energy_o,
  output logic [INDEX_BITS-1:0]         min_index_o,
  output logic [INDEX_BITS-1:0]         sample_cnt_o,
  output logic                          busy_o
`ifdef ENERGY_MIN_TRACKER_SUM_EN
  ,
  output logic signed [ENERGY_BITS+INDEX_BITS-1:0] sum_energy_o
`endif
);

  localparam logic signed [ENERGY_BITS-1:0] MAX_E =
    {1'b0, {(ENERGY_BITS-1){1'b1}}};
  localparam logic [INDEX_BITS-1:0] ONE = 1;
  localparam logic [INDEX_BITS-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    REPORT
  } state_t;

  state_t                        r_state;
  logic                          r_valid;
  logic signed [ENERGY_BITS-1:0] r_min;
  logic [INDEX_BITS-1:0]         r_idx;
  logic [INDEX_BITS-1:0]         r_cnt;
  logic [INDEX_BITS-1:0]         r_target;

  logic                          w_cfg_hs;
  logic                          w_e_hs;
  logic                          w_less;
  logic                          w_last;
  logic [INDEX_BITS-1:0]         w_cnt_nxt;

`ifdef ENERGY_MIN_TRACKER_SUM_EN
  logic signed [ENERGY_BITS+INDEX_BITS-1:0] r_sum;
  logic signed [ENERGY_BITS+INDEX_BITS-1:0] w_ext;
  assign w_ext = {{INDEX_BITS{energy_i[ENERGY_BITS-1]}}, energy_i};
  assign sum_energy_o = r_sum;
`endif

  assign cfg_ready_o    = (r_state == IDLE) && en_i && !flush_i;
  assign energy_ready_o = (r_state == TRACK) && en_i && !flush_i;
  assign w_cfg_hs       = cfg_valid_i && cfg_ready_o;
  assign w_e_hs         = energy_valid_i && energy_ready_o;
  assign w_less         = energy_i < r_min;
  assign w_cnt_nxt      = r_cnt + ONE;
  assign w_last         = (w_cnt_nxt == r_target);

  assign result_valid_o = r_valid;
  assign min_energy_o   = r_min;
  assign min_index_o    = r_idx;
  assign sample_cnt_o   = r_cnt;
  assign busy_o         = (r_state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_valid  <= 1'b0;
      r_min    <= MAX_E;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_target <= '0;
`ifdef ENERGY_MIN_TRACKER_SUM_EN
      r_sum    <= '0;
`endif
    end else if (flush_i) begin
      // Abort keeps the partial statistics visible
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_cfg_hs) begin
            r_target <= cfg_num_samples_i;
            r_min    <= MAX_E;
            r_idx    <= '0;
            r_cnt    <= '0;
`ifdef ENERGY_MIN_TRACKER_SUM_EN
            r_sum    <= '0;
`endif
            if (cfg_num_samples_i == ZERO) begin
              r_state <= REPORT;
              r_valid <= 1'b1;
            end else begin
              r_state <= TRACK;
            end
          end
        end
        TRACK: begin
          if (w_e_hs) begin
            r_cnt <= w_cnt_nxt;
            if (w_less) begin
              r_min <= energy_i;
              r_idx <= r_cnt;
            end
`ifdef ENERGY_MIN_TRACKER_SUM_EN
            r_sum <= r_sum + w_ext;
`endif
            if (w_last) begin
              r_state <= REPORT;
              r_valid <= 1'b1;
            end
          end
        end
        REPORT: begin
          // Result handshake is honoured even with en_i low
          if (result_ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
